// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: format codes (same as the immediate generator) and opcodes.
package instr_encoder_pkg;

  localparam logic [2:0] FMT_I = 3'd0;
  localparam logic [2:0] FMT_S = 3'd1;
  localparam logic [2:0] FMT_B = 3'd2;
  localparam logic [2:0] FMT_U = 3'd3;
  localparam logic [2:0] FMT_J = 3'd4;
  localparam logic [2:0] FMT_R = 3'd5;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  // True when imm[31:msb] are all equal, i.e. the value fits a signed field of msb+1 bits.
  function automatic logic sext_fits(input logic [31:0] imm, input int msb);
    logic signed [31:0] hi;
    hi = $signed(imm) >>> msb;
    return (hi == 32'sd0) || (hi == -32'sd1);
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: scatters fields and immediate into an RV32I word and flags
// immediates that do not survive the round trip through the immediate generator.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic [31:0] ir,
  output logic        err
);

  always_comb begin
    ir  = '0;
    err = 1'b0;
    case (fmt)
      FMT_I: begin
        ir  = {imm[11:0], rs1, funct3, rd, opcode};
        err = !sext_fits(imm, 11);
      end
      FMT_S: begin
        ir  = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        err = !sext_fits(imm, 11);
      end
      FMT_B: begin
        ir  = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        err = !sext_fits(imm, 12) || imm[0];
      end
      FMT_U: begin
        ir  = {imm[31:12], rd, opcode};
        err = (imm[11:0] != 12'd0);
      end
      FMT_J: begin
        ir  = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        err = !sext_fits(imm, 20) || imm[0];
      end
      FMT_R: begin
        ir  = {funct7, rs2, rs1, funct3, rd, opcode};
        err = 1'b0;
      end
      // Illegal format codes emit an all-zero word.
      default: begin
        ir  = '0;
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with error flag and saturating error
// counter (counter present only when INSTR_ENC_ERRCNT_EN is defined).
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2:0]          in_fmt,
  input  logic [6:0]          in_opcode,
  input  logic [4:0]          in_rd,
  input  logic [4:0]          in_rs1,
  input  logic [4:0]          in_rs2,
  input  logic [2:0]          in_funct3,
  input  logic [6:0]          in_funct7,
  input  logic [31:0]         in_imm,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_ir,
  output logic                out_err,
  output logic [ERRCNT_W-1:0] err_count
);

  logic [31:0] pk_ir;
  logic        pk_err;
  logic        s1_valid;
  logic [31:0] s1_ir;
  logic        s1_err;
  logic        s2_load;
  logic        in_fire;

  instr_pack u_pack (
    .fmt    (in_fmt),
    .opcode (in_opcode),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .funct3 (in_funct3),
    .funct7 (in_funct7),
    .imm    (in_imm),
    .ir     (pk_ir),
    .err    (pk_err)
  );

  // in_ready looks only at pipeline state and out_ready, never at in_valid.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_ir     <= '0;
      s1_err    <= 1'b0;
      out_valid <= 1'b0;
      out_ir    <= '0;
      out_err   <= 1'b0;
    end else begin
      if (s2_load) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_ir  <= s1_ir;
          out_err <= s1_err;
        end
      end
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_ir  <= pk_ir;
          s1_err <= pk_err;
        end
      end
    end
  end

`ifdef INSTR_ENC_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (in_fire && pk_err && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`else
  logic unused_fire;
  assign unused_fire = in_fire;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed steps plus randomized traffic against an
// arithmetic reference encoder, a range-based error model and an immediate-generator round trip.
module tb_instr_encoder;
  import instr_encoder_pkg::*;

`ifdef INSTR_ENC_ERRCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, sat_in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [2:0]  in_funct3;
  logic [31:0] in_imm;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_ir;
  logic [15:0] err_count;
  logic        sat_out_valid, sat_out_err;
  logic [31:0] sat_out_ir;
  logic [2:0]  sat_err_count;

  typedef struct {
    logic [31:0] ir;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   exp_cnt  = 0;
  int   sat_cnt  = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ERRCNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_ir(out_ir), .out_err(out_err),
    .err_count(err_count)
  );

  // Narrow-counter instance, always drained, used to reach saturation quickly.
  instr_encoder #(.ERRCNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1),
    .in_rs2(in_rs2), .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(sat_out_valid), .out_ready(1'b1), .out_ir(sat_out_ir), .out_err(sat_out_err),
    .err_count(sat_err_count)
  );

  function automatic logic [31:0] ref_word(input logic [2:0] f, input logic [31:0] op,
      input logic [31:0] rd, input logic [31:0] rs1, input logic [31:0] rs2,
      input logic [31:0] f3, input logic [31:0] f7, input logic [31:0] imm);
    case (f)
      3'd0: return ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      3'd1: return (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12)
                   | ((imm & 32'h1F) << 7) | op;
      3'd2: return (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                   | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                   | (((imm >> 11) & 32'h1) << 7) | op;
      3'd3: return (imm & 32'hFFFFF000) | (rd << 7) | op;
      3'd4: return (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                   | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                   | (rd << 7) | op;
      3'd5: return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_err(input logic [2:0] f, input logic [31:0] imm);
    int si;
    si = $signed(imm);
    case (f)
      3'd0, 3'd1: return (si < -2048) || (si > 2047);
      3'd2:       return (si < -4096) || (si > 4095) || (imm % 2 != 0);
      3'd3:       return (imm % 4096) != 0;
      3'd4:       return (si < -(1 << 20)) || (si > (1 << 20) - 1) || (imm % 2 != 0);
      3'd5:       return 1'b0;
      default:    return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ir, input logic [2:0] f);
    case (f)
      3'd0: return {{20{ir[31]}}, ir[31:20]};
      3'd1: return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      3'd2: return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      3'd3: return {ir[31:12], 12'd0};
      default: return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cur_word();
    return ref_word(in_fmt, 32'(in_opcode), 32'(in_rd), 32'(in_rs1), 32'(in_rs2),
                    32'(in_funct3), 32'(in_funct7), in_imm);
  endfunction

  // Inputs are driven just after a falling edge; tick resolves the handshakes of the
  // coming rising edge in the model and returns on the next falling edge.
  task automatic tick(output bit acc);
    exp_t e;
    bit   rerr;
    #1;
    acc = 1'b0;
    if (rst) begin
      sb.delete();
      exp_cnt = 0;
      sat_cnt = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_word", 32'(out_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("out_ir", out_ir, e.ir);
          chk("out_err", 32'(out_err), 32'(e.err));
          if (!e.err && e.fmt <= 3'd4) chk("round_trip", imm_gen(out_ir, e.fmt), e.imm);
        end
      end
      if (in_valid) begin
        rerr = ref_err(in_fmt, in_imm);
        if (in_ready) begin
          acc = 1'b1;
          e.ir = cur_word(); e.err = rerr; e.fmt = in_fmt; e.imm = in_imm;
          sb.push_back(e);
          if (rerr && exp_cnt != 65535) exp_cnt++;
        end
        if (rerr && sat_cnt != 7) sat_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("err_count", 32'(err_count), CNT_EN ? 32'(exp_cnt) : 32'd0);
    chk("sat_count", 32'(sat_err_count), CNT_EN ? 32'(sat_cnt) : 32'd0);
  endtask

  task automatic req(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
  endtask

  task automatic send(input string tag);
    bit acc;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(acc);
      if (acc) return;
    end
    chk({tag, "_accept_timeout"}, 32'(in_ready), 32'd1);
  endtask

  task automatic drain();
    bit acc;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick(acc);
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    bit          acc;
    logic [31:0] w0;
    int          mode;
    logic [31:0] rimm;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    req(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    @(negedge clk);
    tick(acc); tick(acc);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_ir", out_ir, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // I-type, two-cycle latency
    req(FMT_I, OP_IMM, 5'd1, 5'd2, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF);
    send("i_basic");
    in_valid = 1'b0;
    chk("i_lat_not_yet", 32'(out_valid), 32'd0);
    tick(acc);
    chk("i_lat_valid", 32'(out_valid), 32'd1);
    chk("i_word", out_ir, 32'hFFF1_0093);
    chk("i_err", 32'(out_err), 32'd0);
    drain();

    // B-type, then misaligned branch offset
    req(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
    send("b_neg4");
    req(FMT_B, OP_BRANCH, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
    send("b_odd");
    in_valid = 1'b0;
    chk("b_word", out_ir, 32'hFE00_0EE3);
    chk("b_word_err", 32'(out_err), 32'd0);
    chk("b_odd_cnt", 32'(err_count), CNT_EN ? 32'd1 : 32'd0);
    tick(acc);
    chk("b_odd_err", 32'(out_err), 32'd1);
    drain();

    // J and U encodings, U with nonzero low bits
    req(FMT_J, OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
    send("j_basic");
    req(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    send("u_basic");
    chk("j_word", out_ir, 32'h0010_00EF);
    req(FMT_U, OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001);
    send("u_low");
    chk("u_word", out_ir, 32'h1234_52B7);
    chk("u_word_err", 32'(out_err), 32'd0);
    in_valid = 1'b0;
    tick(acc);
    chk("u_low_err", 32'(out_err), 32'd1);
    drain();

    // Back-pressure: capacity two, output held while stalled, order preserved
    out_ready = 1'b0;
    req(FMT_R, OP_OP, 5'd3, 5'd4, 5'd5, 3'd0, 7'h20, 32'd0);
    w0 = cur_word();
    send("stall0");
    req(FMT_R, OP_OP, 5'd6, 5'd7, 5'd8, 3'd1, 7'h00, 32'd0);
    send("stall1");
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    req(FMT_S, OP_STORE, 5'd0, 5'd9, 5'd10, 3'd2, 7'd0, -32'sd8);
    for (int i = 0; i < 3; i++) begin
      tick(acc);
      chk("stall_hold_ir", out_ir, w0);
      chk("stall_hold_valid", 32'(out_valid), 32'd1);
      chk("stall_ready_low", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    send("stall2");
    req(FMT_I, OP_IMM, 5'd11, 5'd12, 5'd0, 3'd7, 7'd0, 32'd2047);
    send("stall3");
    drain();

    // Range edge and illegal format
    req(FMT_I, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd2048);
    send("i_2048");
    req(3'd7, OP_IMM, 5'd1, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0);
    send("fmt7");
    in_valid = 1'b0;
    chk("i_2048_err", 32'(out_err), 32'd1);
    tick(acc);
    chk("fmt7_err", 32'(out_err), 32'd1);
    chk("fmt7_word", out_ir, 32'd0);
    drain();

    // Drive the narrow counter past all-ones
    req(3'd6, OP_IMM, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    for (int i = 0; i < 9; i++) send("sat");
    drain();
    chk("sat_final", 32'(sat_err_count), CNT_EN ? 32'd7 : 32'd0);

    // Reset with two words in flight
    out_ready = 1'b0;
    req(FMT_I, OP_IMM, 5'd2, 5'd3, 5'd0, 3'd0, 7'd0, 32'd5000);
    send("rst_a");
    req(FMT_I, OP_IMM, 5'd4, 5'd5, 5'd0, 3'd0, 7'd0, 32'd7);
    send("rst_b");
    in_valid = 1'b0;
    rst = 1'b1;
    tick(acc);
    rst = 1'b0;
    chk("rst_fly_valid", 32'(out_valid), 32'd0);
    chk("rst_fly_cnt", 32'(err_count), 32'd0);
    chk("rst_fly_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(acc);
      chk("rst_no_stale", 32'(out_valid), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: rimm = 32'($urandom_range(0, 10000)) - 32'd5000;
        1: rimm = $urandom;
        2: rimm = $urandom & 32'hFFFF_F000;
        default: rimm = (32'($urandom_range(0, 32'h1F_FFFF)) - 32'h10_0000) & 32'hFFFF_FFFE;
      endcase
      req(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
          3'($urandom), 7'($urandom), rimm);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      tick(acc);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Builds RV32I instruction words from separated fields plus a full 32-bit immediate value. It is the inverse of the core's immediate generator and uses the same 3-bit format code (0=I, 1=S, 2=B, 3=U, 4=J), extended with 5=R. It feeds the instruction-memory loader and self-test sequencer. It is a two-stage valid/ready pipeline with immediate range/alignment checking and an error counter.

Parameters:
ERRCNT_W, 16, width of saturating error counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
in_valid  in  1  input request valid
in_ready  out  1  encoder can accept this cycle
in_fmt  in  3  format code: 0=I 1=S 2=B 3=U 4=J 5=R; 6,7 illegal
in_opcode  in  7  opcode field
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2
in_funct3  in  3  funct3 field
in_funct7  in  7  funct7 field (R only)
in_imm  in  32  immediate as the decoded signed/unsigned value
out_valid  out  1  encoded word valid
out_ready  in  1  downstream accepts
out_ir  out  32  encoded instruction word
out_err  out  1  immediate out of range, misaligned, or illegal fmt
err_count  out  ERRCNT_W  saturating count of accepted requests with error

Behaviour:
- Reset (synchronous, active-high, clk): s1/s2 valid=0, out_valid=0, out_ir=0, out_err=0, err_count=0. Reset mid-operation discards both in-flight words; nothing is emitted that cycle.
- Handshake: a transfer occurs when valid&&ready on the same edge. out_ir/out_err are stable while out_valid&&!out_ready. in_ready must not depend combinationally on in_valid.
- Pipeline: S1 registers encoded word + error flag; S2 is the output register.
  - Latency: 2 cycles from in accept to out_valid.
  - Throughput: 1/cycle when out_ready=1.
  - Advance rules: S2 loads when empty or out_ready. S1 advances when S2 loads.
  - in_ready = !s1_valid || s1 advancing.
  - Order is strictly preserved. Capacity is 2 words.
- Encoding (low 7 bits = in_opcode):
  - I: imm[11:0],rs1,f3,rd
  - S: imm[11:5],rs2,rs1,f3,imm[4:0]
  - B: imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11]
  - U: imm[31:12],rd
  - J: imm[20],imm[10:1],imm[11],imm[19:12],rd
  - R: f7,rs2,rs1,f3,rd; in_imm ignored
- Error rules (flag only; the word is still emitted with truncated bits):
  - I/S: in_imm[31:11] not all equal.
  - B: in_imm[31:12] not all equal, or in_imm[0]=1.
  - J: in_imm[31:20] not all equal, or in_imm[0]=1.
  - U: in_imm[11:0]!=0.
  - fmt 6/7: error, out_ir=0.
- Round-trip invariant: if out_err=0 and fmt is I/S/B/U/J, the immediate generator applied to (out_ir, fmt) returns in_imm exactly.
- err_count: increments when an erroring word is accepted at S1. It saturates at all-ones and does not wrap.

Optional Feature:
INSTR_ENC_ERRCNT_EN:
- Defined: err_count register as above.
- Undefined: register removed; err_count tied to 0.
- out_err is unaffected either way.

Decomposition:
- Shared package holds:
  - format codes FMT_I..FMT_R, shared with the immediate generator control.
  - opcode constants OP_LUI, OP_JAL, OP_BRANCH, OP_STORE, OP_IMM, OP_OP.
- One combinational sub-module instr_pack (fields+fmt -> word, err) is instantiated in front of S1.
- Handshake and counter logic stay in instr_encoder.

Test Plan:
- I, op=0010011, rd=1, rs1=2, f3=0, imm=-1 -> out_ir=0xFFF10093, out_err=0, two cycles after accept.
- B, op=1100011, rs1=rs2=0, f3=0, imm=-4 -> 0xFE000EE3; then imm=3 -> out_err=1, err_count=1.
- J, op=1101111, rd=1, imm=0x800 -> 0x001000EF. U, op=0110111, rd=5, imm=0x12345000 -> 0x123452B7. U imm=0x12345001 -> out_err=1.
- Back-to-back 4 requests with out_ready=0 for 3 cycles:
  - in_ready drops after 2 accepts.
  - out_ir holds steady while stalled.
  - all 4 words emerge in order once out_ready=1.
- I imm=2048 and fmt=7 accepted -> out_err=1 on both, fmt 7 gives out_ir=0; preload near saturation -> err_count stops at 0xFFFF.
- Assert rst with 2 words in flight -> next cycle out_valid=0, err_count=0, in_ready=1; no stale word ever appears.
